cell_vector_sweeper: RTL and testbench
======================================

// Module: cell_vector_sweeper
// PURPOSE
//  Sequential stimulus/checker stage that drives the input pins of a 4-input standard cell (AOI211_X2 by default).
//  Sweeps every input vector, waits a settle interval, then samples the cell output ZN.
//  Builds the measured truth table and compares it against an expected table.
//  Replaces hand-written #delay truth-table benches with a clocked, reusable, self-checking stage.
// PARAMETERS
//  N_IN    4        number of cell inputs; vector bit order {A,B,C1,C2}, MSB = A
//  SETTLE  2        clock cycles (>=1) a vector is held before ZN is sampled
//  EXP_TT  16'h0007 expected ZN per vector index (bit i = ZN for vector i); default = AOI211
// PORTS
//  clk       in   1          clock, rising edge
//  rst       in   1          asynchronous reset, active-high
//  start     in   1          begin a sweep; sampled only in IDLE or DONE
//  dut_zn    in   1          output of the cell under test
//  vec_out   out  N_IN       drives {A,B,C1,C2} of the cell
//  busy      out  1          sweep in progress
//  done      out  1          sweep complete; held until next start or reset
//  pass      out  1          measured table == EXP_TT; valid while done=1
//  result    out  2**N_IN    measured truth table, bit i = sampled ZN for vector i
//  fail_cnt  out  N_IN+1     number of mismatching vectors
//  fail_idx  out  N_IN       lowest mismatching vector index; 0 if none
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; vec_out=0, busy=0, done=0, pass=0, result=0, fail_cnt=0, fail_idx=0.
//  - States and transitions:
//    IDLE -(start)-> DRIVE
//    DRIVE -(settle_cnt==SETTLE-1)-> SAMPLE
//    SAMPLE -(not last)-> DRIVE
//    SAMPLE -(last)-> DONE
//    DONE -(start)-> DRIVE
//  - On the start edge: step=0; result, fail_cnt and fail_idx cleared; done=0; busy=1.
//    vec_out = vector(0) from the next cycle.
//  - DRIVE holds vec_out stable for SETTLE cycles. SAMPLE lasts 1 cycle; vec_out is still stable during it.
//  - On the SAMPLE edge:
//    - result[vec] <= dut_zn
//    - on mismatch with EXP_TT[vec]: fail_cnt++ ; fail_idx <= vec if this is the first mismatch
//    - then step++ and the next vector is presented
//  - Per-vector cost = SETTLE+1 cycles. done rises 2**N_IN*(SETTLE+1) cycles after the start edge (48 at defaults).
//  - On entering DONE: busy=0, done=1, pass=(fail_cnt==0) computed with the final compare included.
//    vec_out returns to 0.
//  - start while busy is ignored. start held high in DONE restarts the sweep on each completion.
//  - Step counter is N_IN+1 bits; "last" = step==2**N_IN-1. Wrap-around must not occur.
//  - fail_cnt saturation is impossible: max = 2**N_IN, which fits in N_IN+1 bits.
//  - Reset asserted mid-sweep aborts at once. No partial result is retained.
// CONFIGURATION
//  - SWEEP_GRAY_EN defined: vector(step) = step ^ (step>>1), so exactly one input toggles per step (glitch-free stimulus).
//    result/EXP_TT stay indexed by the vector value, not by step.
//  - SWEEP_GRAY_EN undefined: vector(step) = step (binary order 0000..1111).
//  - Timing and latency are identical in both builds.
// STRUCTURE
//  - Package cell_sweep_pkg:
//    - state enum {IDLE, DRIVE, SAMPLE, DONE}
//    - function bin2gray
//    - localparam AOI211_TT = 16'h0007
//  - Sub-module cell_sweep_seq: step counter, last flag, vector encode (binary/Gray).
//    The top holds the FSM, settle timer and checker.
// TESTING
//  - Reset: rst=1 for 3 cycles -> all outputs 0; assert rst async (mid-cycle) -> outputs clear before the next clk edge.
//  - Golden sweep: connect a behavioural AOI211 (ZN=~(A|B|(C1&C2))), pulse start.
//    -> done after 48 cycles; result=16'h0007, pass=1, fail_cnt=0.
//  - Fault model: ZN stuck-at-0 -> result=16'h0000, pass=0, fail_cnt=3, fail_idx=0.
//    ZN stuck-at-1 -> fail_cnt=13, fail_idx=3.
//  - Busy/restart:
//    - start pulsed at cycle 10 of a sweep -> ignored, done still at cycle 48.
//    - start in DONE -> done drops next cycle and a second sweep completes with the same result.
//  - Abort: rst at cycle 20 of a sweep, then start -> clean full sweep, result=16'h0007.
//  - SWEEP_GRAY_EN build: monitor vec_out -> Hamming distance 1 between consecutive vectors; all 16 vectors visited.
//    result=16'h0007.

Source files
------------

// File: rtl/cell_sweep_pkg.sv
// cell_sweep_pkg -- shared types and constants for the cell vector sweeper.
// Optional build macro used by the sweeper: SWEEP_GRAY_EN (Gray-ordered stimulus).
`timescale 1ns/1ps
package cell_sweep_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Expected ZN table of AOI211: ZN = ~(A | B | (C1 & C2)), vector {A,B,C1,C2}.
  // Only vectors 0..2 (A=B=0 and C1&C2=0) drive ZN high.
  localparam logic [15:0] AOI211_TT = 16'h0007;

  // Binary to reflected Gray code; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cell_sweep_seq.sv
// cell_sweep_seq -- step counter, last-step flag and stimulus vector encoder.
// With SWEEP_GRAY_EN defined the vector is the Gray code of the step, so only
// one cell input toggles between consecutive vectors; otherwise it is the step.
`timescale 1ns/1ps
module cell_sweep_seq
  import cell_sweep_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  output logic            last,
  output logic [N_IN-1:0] vec
);

  // One extra bit so the counter can never wrap while reaching 2**N_IN-1.
  localparam int            LAST_I    = (1 << N_IN) - 1;
  localparam logic [N_IN:0] LAST_STEP = LAST_I[N_IN:0];
  localparam logic [N_IN:0] STEP_ONE  = {{N_IN{1'b0}}, 1'b1};

  logic [N_IN:0]   r_step;
  logic [N_IN-1:0] w_bin;

  assign w_bin = r_step[N_IN-1:0];
  assign last  = (r_step == LAST_STEP);

  // Step counter: cleared on launch, advanced after each sample, parked on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
    end else if (clear) begin
      r_step <= '0;
    end else if (advance && !last) begin
      r_step <= r_step + STEP_ONE;
    end
  end

`ifdef SWEEP_GRAY_EN
  // Gray-ordered stimulus: vector(step) = step ^ (step >> 1).
  assign vec = N_IN'(bin2gray(32'(w_bin)));
`else
  // Binary-ordered stimulus: vector(step) = step.
  assign vec = w_bin;
`endif

endmodule

// File: rtl/cell_vector_sweeper.sv
// cell_vector_sweeper -- clocked truth-table sweeper/checker for a 4-input cell.
// Drives every input vector, holds it SETTLE cycles, samples ZN for one cycle,
// builds the measured table and compares it against EXP_TT.
// Build macro: SWEEP_GRAY_EN selects Gray-ordered stimulus (timing unchanged).
`timescale 1ns/1ps
module cell_vector_sweeper
  import cell_sweep_pkg::*;
#(
  parameter int                    N_IN   = 4,
  parameter int                    SETTLE = 2,
  parameter logic [(2**N_IN)-1:0]  EXP_TT = AOI211_TT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dut_zn,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(2**N_IN)-1:0]   result,
  output logic [N_IN:0]          fail_cnt,
  output logic [N_IN-1:0]        fail_idx
);

  // Settle timer only needs to count 0..SETTLE-1.
  localparam int              SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [SCW-1:0]  SETTLE_ONE  = SCW'(1);
  localparam logic [N_IN:0]   FAIL_ONE    = {{N_IN{1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SCW-1:0]         r_settle_cnt;
  logic [(2**N_IN)-1:0]   r_result;
  logic [N_IN:0]          r_fail_cnt;
  logic [N_IN-1:0]        r_fail_idx;
  logic                   r_pass;

  logic                   w_launch;
  logic                   w_sample;
  logic                   w_settle_done;
  logic                   w_last;
  logic [N_IN-1:0]        w_vec;
  logic                   w_mismatch;
  logic                   w_no_fail;

  // Start is honoured only when no sweep is running.
  assign w_launch      = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_sample      = (r_state == SAMPLE);
  assign w_settle_done = (r_state == DRIVE) && (r_settle_cnt == SETTLE_LAST);
  assign w_mismatch    = dut_zn ^ EXP_TT[w_vec];
  assign w_no_fail     = (r_fail_cnt == '0);

  cell_sweep_seq #(
    .N_IN (N_IN)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_launch),
    .advance (w_sample),
    .last    (w_last),
    .vec     (w_vec)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)         w_state_next = DRIVE;
      DRIVE:   if (w_settle_done) w_state_next = SAMPLE;
      SAMPLE:  w_state_next = w_last ? DONE : DRIVE;
      DONE:    if (start)         w_state_next = DRIVE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: the vector is only presented while a sweep is running.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    vec_out = '0;
    case (r_state)
      DRIVE, SAMPLE: begin
        busy    = 1'b1;
        vec_out = w_vec;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Settle timer: counts DRIVE cycles, restarts for every vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= '0;
    end else if ((r_state == DRIVE) && !w_settle_done) begin
      r_settle_cnt <= r_settle_cnt + SETTLE_ONE;
    end else begin
      r_settle_cnt <= '0;
    end
  end

  // Checker: record ZN per vector, count mismatches, keep the lowest failing
  // vector, and settle pass on the final sample including that last compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result   <= '0;
      r_fail_cnt <= '0;
      r_fail_idx <= '0;
      r_pass     <= 1'b0;
    end else if (w_launch) begin
      r_result   <= '0;
      r_fail_cnt <= '0;
      r_fail_idx <= '0;
      r_pass     <= 1'b0;
    end else if (w_sample) begin
      r_result[w_vec] <= dut_zn;
      if (w_mismatch) begin
        r_fail_cnt <= r_fail_cnt + FAIL_ONE;
        if (w_no_fail || (w_vec < r_fail_idx)) begin
          r_fail_idx <= w_vec;
        end
      end
      if (w_last) begin
        r_pass <= w_no_fail && !w_mismatch;
      end
    end
  end

  assign result   = r_result;
  assign fail_cnt = r_fail_cnt;
  assign fail_idx = r_fail_idx;
  assign pass     = r_pass;

endmodule

// File: tb/tb_cell_vector_sweeper.sv
// tb_cell_vector_sweeper -- randomized scoreboard bench for cell_vector_sweeper.
// Stimulus pushes the expected sweep outcome; a negedge monitor pops it when done rises.
`timescale 1ns/1ps
module tb_cell_vector_sweeper;

  localparam int          N_IN      = 4;
  localparam int          SETTLE    = 2;
  localparam int          NV        = 16;
  localparam int          SWEEP_CYC = NV * (SETTLE + 1);
  localparam int          BUDGET    = 200;
  localparam logic [15:0] EXP_TT    = 16'h0007;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dut_zn;
  logic [3:0]  vec_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] result;
  logic [4:0]  fail_cnt;
  logic [3:0]  fail_idx;

  always #5 clk = ~clk;

  cell_vector_sweeper #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE),
    .EXP_TT (EXP_TT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dut_zn   (dut_zn),
    .vec_out  (vec_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .result   (result),
    .fail_cnt (fail_cnt),
    .fail_idx (fail_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural cell: either a real AOI211 or an arbitrary (faulty) table.
  bit          golden_mode;
  logic [15:0] cell_tt;

  function automatic logic aoi211(input logic [3:0] v);
    return ~(v[3] | v[2] | (v[1] & v[0]));
  endfunction

  always_comb dut_zn = golden_mode ? aoi211(vec_out) : cell_tt[vec_out];

  // Reference model: what a complete sweep of a given cell table must report.
  typedef struct packed {
    logic [15:0] result;
    logic [4:0]  fcnt;
    logic [3:0]  fidx;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [15:0] golden_table();
    logic [15:0] t;
    logic [3:0]  v;
    t = '0;
    for (int i = 0; i < NV; i++) begin
      v    = 4'(i);
      t[i] = aoi211(v);
    end
    return t;
  endfunction

  function automatic exp_t ref_model(input logic [15:0] tt);
    exp_t        r;
    logic [15:0] diff;
    diff     = tt ^ EXP_TT;
    r.result = tt;
    r.fcnt   = 5'($countones(diff));
    r.fidx   = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (diff[i]) r.fidx = 4'(i);
    end
    r.pass = (diff == 16'h0000);
    return r;
  endfunction

  // Monitor: sweep timing, stimulus ordering/coverage and scoreboard compare.
  initial begin
    int          busy_cycles;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  prev_vec;
    logic [3:0]  nxt_vec;
    logic [15:0] visited;
    int          sweep_no;
    exp_t        e;
    busy_cycles = 0;
    busy_q      = 1'b0;
    done_q      = 1'b0;
    prev_vec    = '0;
    visited     = '0;
    sweep_no    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cycles = 0;
        busy_q      = 1'b0;
        done_q      = 1'b0;
        visited     = '0;
      end else begin
        if (busy && !busy_q) begin
          check("first_vec", vec_out, 4'd0);
          prev_vec = vec_out;
          visited  = 16'h0001 << vec_out;
        end else if (busy && (vec_out != prev_vec)) begin
`ifdef SWEEP_GRAY_EN
          check("vec_hamming", $countones(vec_out ^ prev_vec), 1);
`else
          nxt_vec = prev_vec + 4'd1;
          check("vec_order", vec_out, nxt_vec);
`endif
          prev_vec = vec_out;
          visited  = visited | (16'h0001 << vec_out);
        end
        if (busy) busy_cycles++;
        if (done && !done_q) begin
          sweep_no++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done required=no_sweep_pending");
          end else begin
            e = exp_q.pop_front();
            $display("sweep %0d: result=%h fail_cnt=%0d fail_idx=%0d pass=%0b cycles=%0d",
                     sweep_no, result, fail_cnt, fail_idx, pass, busy_cycles);
            check("result",    result,      e.result);
            check("fail_cnt",  fail_cnt,    e.fcnt);
            check("fail_idx",  fail_idx,    e.fidx);
            check("pass",      pass,        e.pass);
            check("latency",   busy_cycles, SWEEP_CYC);
            check("visited",   visited,     16'hffff);
            check("vec_idle",  vec_out,     4'd0);
            check("busy_done", busy,        1'b0);
          end
          busy_cycles = 0;
        end
        busy_q = busy;
        done_q = done;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"},      vec_out,  4'd0);
    check({tag, "_busy"},     busy,     1'b0);
    check({tag, "_done"},     done,     1'b0);
    check({tag, "_pass"},     pass,     1'b0);
    check({tag, "_result"},   result,   16'h0000);
    check({tag, "_fail_cnt"}, fail_cnt, 5'd0);
    check({tag, "_fail_idx"}, fail_idx, 4'd0);
  endtask

  // One sweep, entered at a negedge; poke>0 pulses start mid-sweep at that cycle.
  task automatic run_sweep(input logic [15:0] tt, input bit golden, input int poke);
    bit found;
    bit was_done;
    golden_mode = golden;
    cell_tt     = tt;
    exp_q.push_back(ref_model(golden ? golden_table() : tt));
    was_done = done;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (was_done) check("restart_done_drop", done, 1'b0);
    check("busy_after_start", busy, 1'b1);
    found = 1'b0;
    for (int k = 1; k <= BUDGET && !found; k++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else      start = (k == poke);
    end
    start = 1'b0;
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout actual=no_done required=done_within_%0d", BUDGET);
    end
  endtask

  initial begin
    logic [15:0] tt;
    rst         = 1'b1;
    start       = 1'b0;
    golden_mode = 1'b1;
    cell_tt     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Golden sweep with an ignored mid-sweep start, then a restart from DONE.
    run_sweep(16'h0000, 1'b1, 10);
    run_sweep(16'h0000, 1'b1, 0);
    // Stuck-at faults.
    run_sweep(16'h0000, 1'b0, 0);
    run_sweep(16'hffff, 1'b0, 0);

    // Abort mid-sweep with an asynchronous reset, then a clean sweep.
    golden_mode = 1'b1;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep(16'h0000, 1'b1, 0);

    // Randomized cell tables, some a single bit away from the expected table.
    for (int i = 0; i < 8; i++) begin
      tt = 16'($urandom);
      if (i == 2) tt = EXP_TT;
      else if (i % 3 == 0) tt = EXP_TT ^ (16'h0001 << $urandom_range(15, 0));
      run_sweep(tt, 1'b0, (i == 5) ? 30 : 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
